beatmap_scroller: RTL
=====================

# beatmap_scroller

Consumes the slow beat clock from the beat clock divider and turns it into a scrolling note field for the rhythm game. On each rising beat edge it fetches the next note row from a synchronous beatmap ROM and shifts it into a DEPTH-row lane buffer. The display stage reads the buffer, and the hit-judge stage reads the bottom row. It runs entirely in the 50 MHz `clk` domain; `beat_clk` is used only as data, never as a clock.

## Interface
- LANES, 4: note lanes per row
- DEPTH, 8: rows held in the visible buffer
- ADDR_W, 8: beatmap ROM address width
- clk  in  1  50 MHz system clock
- reset  in  1  synchronous, active-high reset
- beat_clk  in  1  divided beat clock, registered in the `clk` domain
- start  in  1  one-cycle pulse; begins a song from address 0
- pause  in  1  level; while high, beat edges are ignored
- rom_addr  out  ADDR_W  beatmap ROM address
- rom_data  in  LANES+1  ROM row, valid 1 cycle after `rom_addr`; bit LANES = end-of-song flag, bits LANES-1:0 = notes
- lane_rows  out  DEPTH*LANES  buffer contents; row r occupies bits [r*LANES +: LANES]; row 0 is top (newest)
- hit_row  out  LANES  equal to row DEPTH-1 of `lane_rows`
- step_pulse  out  1  high for one cycle when the buffer has just shifted
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE

## Operation
- States: IDLE, WAIT_TICK, FETCH, LOAD, DRAIN, DONE.
- Tick definition: `tick = beat_clk & ~beat_q`, where `beat_q` is `beat_clk` delayed by one register. Only rising edges count.
- IDLE: on `start`, clear `lane_rows`, set `rom_addr`=0, set the drain counter to 0, go to WAIT_TICK.
- WAIT_TICK: on `tick & ~pause`, go to FETCH. A tick seen while `pause` is high is discarded, not deferred.
- FETCH: wait one cycle for ROM data, then go to LOAD.
- LOAD, end flag = 0:
  - Shift `lane_rows` down one row; row 0 takes `rom_data[LANES-1:0]`; row DEPTH-1 is discarded.
  - Increment `rom_addr`, then return to WAIT_TICK.
- LOAD, end flag = 1: shift in a zero row, leave `rom_addr` unchanged, go to DRAIN.
- Address wrap: if `rom_addr` = 2^ADDR_W-1 and the end flag is 0, shift the row in as normal, then go to DRAIN with `rom_addr` held. It does not wrap to 0.
- DRAIN:
  - On each `tick & ~pause`, shift in a zero row and increment the drain counter.
  - When the counter reaches DEPTH-1, go to DONE. In total DEPTH zero rows enter after the last note, so the buffer is empty on entering DONE.
- DONE: hold outputs. `start` restarts the song exactly as from IDLE.
- `start` in WAIT_TICK, FETCH, LOAD or DRAIN is ignored.
- Ticks arriving in FETCH or LOAD are dropped. The beat period is about 2M cycles, so this does not occur in normal operation.

## Timing
- Reset: state IDLE; `rom_addr`=0, `lane_rows`=0, `hit_row`=0, `step_pulse`=0, `busy`=0, `done`=0; `beat_q`=0; drain counter=0.
- Reset asserted mid-song overrides everything on the next edge. There is no drain and no `done` pulse.
- Cycle numbering: `beat_clk` rises, and `tick` is first high, in cycle T.
  - Cycle T+1: FETCH.
  - Cycle T+2: LOAD.
  - Cycle T+3: `lane_rows`, `hit_row` and `rom_addr` show their new values and `step_pulse` is high for exactly one cycle.
- Tick-to-visible latency is 3 cycles.
- `step_pulse` also fires on every DRAIN shift, in the cycle after the tick.
- `done` rises in the cycle after the final drain tick and stays high until `start` or `reset`.
- All outputs are registered; none depend combinationally on inputs.

## Structure
- Shared package `beatmap_pkg`:
  - state enum
  - `LANES`
  - `ROW_W` = LANES+1
  - `END_BIT` = LANES
  - the ROM row type
- Sub-module `beat_edge_detect` (clk, reset, in, rise):
  - one register plus AND gate
  - reused by the hit-judge stage.
- ROM stays outside this block. It is connected through `rom_addr`/`rom_data`.

## Test plan
- Reset/idle: assert `reset` for 3 cycles, then toggle `beat_clk` 5 times without `start` → all outputs 0, `rom_addr` stays 0, no `step_pulse`.
- Basic scroll: ROM rows 0..2 = 4'b0001, 4'b0010, 4'b0100; `start`; 3 beat rises → after the third, rows 0..2 of `lane_rows` = 0100, 0010, 0001; `rom_addr`=3; each `step_pulse` exactly 3 cycles after its rise.
- Pause: `pause` high across 2 rises, then low for 1 rise → exactly 1 shift, `rom_addr` advances by 1.
- End and drain with DEPTH=8: ROM row 2 has the end flag; 3 rises, then 7 more → `done`=1 after the 10th rise, `lane_rows`=0, `rom_addr`=2, and 8 zero rows shifted in after row 1.
- Hit row: DEPTH=8, first row 4'b1000 → `hit_row`=4'b1000 after exactly 8 shifts and 0 after the 9th.
- Reset mid-song: assert `reset` in the LOAD cycle → next cycle shows IDLE values; the following `start` begins again from `rom_addr`=0.

Source files
------------

// File: rtl/beatmap_scroller_pkg.sv
// Shared types and constants for the beatmap scroller and its neighbours.
// One ROM row holds LANES note bits plus an end-of-song flag in the top bit.
package beatmap_pkg;

    localparam int unsigned LANES   = 4;
    localparam int unsigned ROW_W   = LANES + 1;
    localparam int unsigned END_BIT = LANES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_FETCH,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic             end_flag;
        logic [LANES-1:0] notes;
    } rom_row_t;

    function automatic logic row_is_end(input logic [ROW_W-1:0] row);
        return row[END_BIT];
    endfunction

endpackage

// File: rtl/beatmap_scroller_if.sv
// Beatmap ROM bus: address out from the scroller, row data back one cycle later.
interface beatmap_scroller_if
    import beatmap_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) ();

    logic [ADDR_W-1:0] rom_addr;
    logic [ROW_W-1:0]  rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);

endinterface

// File: rtl/beatmap_scroller_edge.sv
// Rising-edge detector for a slow level sampled in the clk domain.
// Also used by the hit-judge stage.
module beat_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic beat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q <= 1'b0;
        end else begin
            beat_q <= in;
        end
    end

    assign rise = in & ~beat_q;

endmodule

// File: rtl/beatmap_scroller.sv
// Scrolls beatmap ROM rows into a DEPTH-row lane buffer, one row per beat edge,
// then drains the buffer with zero rows once the song ends.
module beatmap_scroller
    import beatmap_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     beat_clk,
    input  logic                     start,
    input  logic                     pause,
    beatmap_scroller_if.master       rom,
    output logic [DEPTH*LANES-1:0]   lane_rows,
    output logic [LANES-1:0]         hit_row,
    output logic                     step_pulse,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned CNT_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DEPTH*LANES-1:0] rows_q, rows_d;
    logic [CNT_W-1:0]       drain_q, drain_d;
    logic                   step_q, step_d;
    logic                   tick;
    logic                   beat_ok;
    rom_row_t               rom_row;

    beat_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .in    (beat_clk),
        .rise  (tick)
    );

    assign rom_row = rom_row_t'(rom.rom_data);
    assign beat_ok = tick & ~pause;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rows_d  = rows_q;
        drain_d = drain_q;
        step_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    rows_d  = '0;
                    addr_d  = '0;
                    drain_d = '0;
                    state_d = ST_WAIT_TICK;
                end
            end
            ST_WAIT_TICK: begin
                if (beat_ok) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                step_d = 1'b1;
                if (row_is_end(rom.rom_data)) begin
                    rows_d  = {rows_q[(DEPTH-1)*LANES-1:0], {LANES{1'b0}}};
                    state_d = ST_DRAIN;
                end else begin
                    rows_d = {rows_q[(DEPTH-1)*LANES-1:0], rom_row.notes};
                    // The last ROM address ends the song instead of wrapping to 0.
                    if (addr_q == '1) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_WAIT_TICK;
                    end
                end
            end
            ST_DRAIN: begin
                if (beat_ok) begin
                    rows_d  = {rows_q[(DEPTH-1)*LANES-1:0], {LANES{1'b0}}};
                    step_d  = 1'b1;
                    drain_d = drain_q + CNT_W'(1);
                    if (drain_q == CNT_W'(DEPTH - 2)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rows_q  <= '0;
            drain_q <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rows_q  <= rows_d;
            drain_q <= drain_d;
            step_q  <= step_d;
        end
    end

    assign rom.rom_addr = addr_q;
    assign lane_rows    = rows_q;
    assign hit_row      = rows_q[(DEPTH-1)*LANES +: LANES];
    assign step_pulse   = step_q;
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done         = (state_q == ST_DONE);

endmodule
